ioblock_cfg_ctrl: RTL

IOBLOCK_CFG_CTRL -- requirements
Module: ioblock_cfg_ctrl

---
 rtl/ioblock_cfg_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ioblock_cfg_ctrl.sv
// Shadow configuration store and serial loader for the IO block TSMUX/DORREG chain.
// Define IOB_CFG_READBACK_EN to capture the previous chain contents from SDI into a readable array.
module ioblock_cfg_ctrl #(
  parameter int NUM_IOB = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              IOCLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [2:0]        WR_DATA,
  input  logic              START,
`ifdef IOB_CFG_READBACK_EN
  input  logic              SDI,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [2:0]        RD_DATA,
`endif
  output logic              BUSY,
  output logic              SEN,
  output logic              SDO,
  output logic              UPDATE,
  output logic              DONE,
  output logic              WR_ERR
);

  localparam int N  = 3 * NUM_IOB;
  localparam int CW = $clog2(N + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_IOB - 1);
  localparam logic [ADDR_W:0]   NUM_W     = (ADDR_W + 1)'(NUM_IOB);
  localparam logic [CW-1:0]     N_CNT     = CW'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    UPD   = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [1:0]        bit_r, bit_s;
  logic              busy_r, busy_s;
  logic              sen_r, sen_s;
  logic              sdo_r, sdo_s;
  logic              upd_r, upd_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic [2:0]        shadow_r [NUM_IOB];
  logic              addr_ok_s, wr_ok_s, start_ok_s;
  logic [2:0]        head_word_s;

  assign addr_ok_s  = ({1'b0, WR_ADDR} < NUM_W);
  assign wr_ok_s    = WR_EN && (state_r == IDLE) && addr_ok_s;
  assign start_ok_s = START && (state_r == IDLE);
  // A write landing in the START cycle must already be visible in the first shifted bit.
  assign head_word_s = (wr_ok_s && (WR_ADDR == LAST_ADDR)) ? WR_DATA : shadow_r[LAST_ADDR];

  // Next-state and registered-output computation for the load sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    bit_s   = bit_r;
    busy_s  = busy_r;
    sen_s   = 1'b0;
    sdo_s   = 1'b0;
    upd_s   = 1'b0;
    done_s  = 1'b0;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_s = SHIFT;
          busy_s  = 1'b1;
          sen_s   = 1'b1;
          sdo_s   = head_word_s[2];
          cnt_s   = CW'(1);
          addr_s  = LAST_ADDR;
          bit_s   = 2'd1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_r == N_CNT) begin
          state_s = UPD;
          upd_s   = 1'b1;
        end else begin
          sen_s = 1'b1;
          sdo_s = shadow_r[addr_r][bit_r];
          cnt_s = cnt_r + CW'(1);
          if (bit_r == 2'd0) begin
            bit_s  = 2'd2;
            addr_s = (addr_r != {ADDR_W{1'b0}}) ? addr_r - ADDR_W'(1) : addr_r;
          end else begin
            bit_s  = bit_r - 2'd1;
          end
        end
      end
      UPD: begin
        state_s = FIN;
        done_s  = 1'b1;
      end
      FIN: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
    if (WR_EN && !wr_ok_s) begin
      err_s = 1'b1;
    end else if (start_ok_s) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      bit_r   <= 2'd0;
      busy_r  <= 1'b0;
      sen_r   <= 1'b0;
      sdo_r   <= 1'b0;
      upd_r   <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      bit_r   <= bit_s;
      busy_r  <= busy_s;
      sen_r   <= sen_s;
      sdo_r   <= sdo_s;
      upd_r   <= upd_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  // Shadow configuration words.
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_IOB; i++) shadow_r[i] <= 3'b000;
    end else if (wr_ok_s) begin
      shadow_r[WR_ADDR] <= WR_DATA;
    end
  end

`ifdef IOB_CFG_READBACK_EN
  logic [2:0]        rb_r [NUM_IOB];
  logic [ADDR_W-1:0] rb_addr_r;
  logic [1:0]        rb_bit_r;

  // Capture the chain tail on every shift cycle, in the same word/bit order as the outgoing data.
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_IOB; i++) rb_r[i] <= 3'b000;
      rb_addr_r <= {ADDR_W{1'b0}};
      rb_bit_r  <= 2'd0;
    end else if (start_ok_s) begin
      rb_addr_r <= LAST_ADDR;
      rb_bit_r  <= 2'd2;
    end else if (sen_r) begin
      rb_r[rb_addr_r][rb_bit_r] <= SDI;
      if (rb_bit_r == 2'd0) begin
        rb_bit_r  <= 2'd2;
        rb_addr_r <= (rb_addr_r != {ADDR_W{1'b0}}) ? rb_addr_r - ADDR_W'(1) : rb_addr_r;
      end else begin
        rb_bit_r  <= rb_bit_r - 2'd1;
      end
    end
  end

  assign RD_DATA = ({1'b0, RD_ADDR} < NUM_W) ? rb_r[RD_ADDR] : 3'b000;
`endif

  assign BUSY   = busy_r;
  assign SEN    = sen_r;
  assign SDO    = sdo_r;
  assign UPDATE = upd_r;
  assign DONE   = done_r;
  assign WR_ERR = err_r;

endmodule
